barrett_reduce_pipe: RTL and testbench
======================================

BARRETT_REDUCE_PIPE -- requirements
Module: barrett_reduce_pipe

Interface
REQ-001 Parameter Q, default 998244353, odd modulus; 2 <= Q < 2^32.
REQ-002 Parameter K, default 30, bit-length of Q; 2^(K-1) <= Q < 2^K.
REQ-003 Localparam MU, fixed at elaboration: floor(2^(2K)/Q), K+1 bits.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_data  input  64  64-bit product from the upstream 32x32 multiplier.
REQ-009 in_ready  output  1  the block accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_data  output  32  in_data mod Q, zero-extended above K bits.
REQ-012 out_ready  input  1  the downstream stage accepts out_data.
REQ-013 out_err  output  1  the result at the output came from an input >= Q*Q.

Function
REQ-014 Transfer on each side SHALL occur only when valid and ready are both high at a rising clk edge.
REQ-015 Pipeline SHALL have 3 register stages, S1 to S3, each with its own valid bit; latency from input transfer to out_valid SHALL be 3 cycles when there is no stall.
REQ-016 S1 SHALL register x = in_data, q3 = ((x >> (K-1)) * MU) >> (K+1), and err = (x >= Q*Q).
REQ-017 S2 SHALL register r = (x mod 2^(K+1)) - ((q3*Q) mod 2^(K+1)), taken mod 2^(K+1) as unsigned.
REQ-018 S3 SHALL register r minus Q applied 0, 1 or 2 times, so that the result is in [0, Q-1].
  - Two correction comparators in series are allowed.
  - Splitting them across S2/S3 is allowed if latency stays 3.
REQ-019 For in_data < Q*Q, out_data SHALL equal in_data mod Q exactly.
REQ-020 For in_data >= Q*Q, out_err SHALL be 1 and out_data is don't-care.
REQ-021 Stall: when out_valid=1 and out_ready=0, all stages SHALL hold and in_ready SHALL be 0.
REQ-022 Bubble collapse: a stage with valid=0 SHALL accept data from the stage before it even while the stages after it are stalled.
  - in_ready SHALL be 0 only when all three stages are valid and out_ready=0.
REQ-023 in_ready SHALL be combinational from out_ready and the stage valid bits only, never from in_valid.
REQ-024 Full throughput: with in_valid=1 and out_ready=1 held, the block SHALL accept one input and emit one result per cycle.
  - Order SHALL be preserved; no result is dropped or duplicated.
REQ-025 While stalled, out_data, out_err and out_valid SHALL stay stable until the output transfer.
REQ-026 Simultaneous input and output transfer in the same cycle SHALL be lossless.
REQ-027 Data registers of invalid stages are don't-care.
  - out_data SHALL be forced to 0 whenever out_valid=0.

Reset
REQ-028 On rst=1, all stage valid bits SHALL clear immediately, giving out_valid=0, out_data=0 and out_err=0.
REQ-029 in_ready SHALL be 1 during reset and after reset.
REQ-030 Reset mid-operation SHALL discard all in-flight results; none appears after reset is released.
REQ-031 The first input transfer is possible on the first clk edge after rst falls.

Verification
REQ-032 Q=998244353, K=30, out_ready=1. Single inputs: 0 -> 0; 12345 -> 12345; Q -> 0; 2^32 -> 301989884; (Q-1)^2 -> 1. Each result SHALL appear exactly 3 cycles after acceptance, with out_err=0.
REQ-033 Back-to-back stream of 1000 random products a*b, with a,b < Q, held at in_valid=1, out_ready=1 -> one result per cycle, in order, each matching a software a*b mod Q.
REQ-034 Fill the pipe with 3 values, then hold out_ready=0 for 5 cycles -> in_ready=0; out_data is frozen on the first result; then release out_ready -> 3 results in order with no loss.
REQ-035 Random in_valid and out_ready with 50% duty each, 2000 transfers -> scoreboard matches; no drop or duplication; in_ready never 0 while any stage is empty or out_ready=1.
REQ-036 Input Q*Q -> out_err=1. Input 2^64-1 -> out_err=1. Neither disturbs the result that follows.
REQ-037 Assert rst asynchronously, mid-clock, while 3 results are in flight -> out_valid drops to 0 before the next edge; no stale result after release; the next input 7 -> 7.

Source files
------------

// File: rtl/barrett_reduce_pipe.sv
// Three-stage Barrett reduction of a 64-bit product modulo a fixed odd Q.
// Each stage has its own valid bit; a ready chain lets empty stages refill while later ones stall.
module barrett_reduce_pipe #(
    parameter logic [63:0] Q = 64'd998244353,
    parameter int          K = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        out_err
);

    localparam int             MUW  = K + 1;
    // One guard bit above K+1: the uncorrected residue can reach 3Q, which may exceed 2^(K+1).
    localparam int             RW   = K + 2;
    localparam logic [MUW-1:0] MU   = MUW'((128'd1 << (2 * K)) / {64'd0, Q});
    localparam logic [127:0]   MU_W = 128'(MU);
    localparam logic [RW-1:0]  QR   = RW'(Q);
    localparam logic [63:0]    QQ   = Q * Q;

    logic            r_v1, r_v2, r_v3;
    logic [RW-1:0]   r_x1, r_q3;
    logic            r_err1, r_err2, r_err3;
    logic [RW-1:0]   r_r2;
    logic [RW-1:0]   r_res;

    logic            w_rdy1, w_rdy2, w_rdy3;
    logic [RW-1:0]   w_q3;
    logic [RW-1:0]   w_r2;
    logic [RW-1:0]   w_c1, w_c2;

    assign w_rdy3   = !r_v3 || out_ready;
    assign w_rdy2   = !r_v2 || w_rdy3;
    assign w_rdy1   = !r_v1 || w_rdy2;
    assign in_ready = w_rdy1;

    // Only q3 mod 2^RW is ever needed, since the residue is formed mod 2^RW.
    assign w_q3 = RW'((({64'd0, in_data} >> (K - 1)) * MU_W) >> (K + 1));
    assign w_r2 = r_x1 - RW'(r_q3 * QR);
    assign w_c1 = (r_r2 >= QR) ? (r_r2 - QR) : r_r2;
    assign w_c2 = (w_c1 >= QR) ? (w_c1 - QR) : w_c1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_x1   <= '0;
            r_q3   <= '0;
            r_err1 <= 1'b0;
        end else if (w_rdy1) begin
            r_v1   <= in_valid;
            r_x1   <= in_data[RW-1:0];
            r_q3   <= w_q3;
            r_err1 <= (in_data >= QQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_r2   <= '0;
            r_err2 <= 1'b0;
        end else if (w_rdy2) begin
            r_v2   <= r_v1;
            r_r2   <= w_r2;
            r_err2 <= r_err1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3   <= 1'b0;
            r_res  <= '0;
            r_err3 <= 1'b0;
        end else if (w_rdy3) begin
            r_v3   <= r_v2;
            r_res  <= w_c2;
            r_err3 <= r_err2;
        end
    end

    assign out_valid = r_v3;
    assign out_data  = r_v3 ? 32'(r_res) : 32'd0;
    assign out_err   = r_v3 && r_err3;

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Bench for barrett_reduce_pipe: directed vectors, streaming, stall, error inputs and mid-cycle reset.
// A negedge monitor scoreboards every output transfer and the in_ready rule every cycle.
module tb_barrett_reduce_pipe;

    localparam logic [63:0] Q  = 64'd998244353;
    localparam int          K  = 30;
    localparam logic [63:0] QQ = Q * Q;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        latChk;
        int          acceptCycle;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        out_err;

    expEntry_t   expQ[$];
    int          checkCount = 0;
    int          errorCount = 0;
    int          cycleCount = 0;
    logic [31:0] tbExpData;
    logic        tbExpErr;
    logic        tbLatChk;
    logic        rdyRandom = 1'b0;
    logic        rdyFixed  = 1'b1;

    barrett_reduce_pipe #(.Q(Q), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // out_ready changes late in the cycle so the driver's flag updates take effect in the same cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdyRandom ? 1'($urandom_range(1, 0)) : rdyFixed;
        end
    end

    always @(negedge clk) begin : monitorBlk
        expEntry_t e;
        int        occ;
        cycleCount++;
        if (!rst) begin
            occ = expQ.size();
            checkOutput("inReady", 64'(in_ready), (occ >= 3 && !out_ready) ? 64'd0 : 64'd1);
            if (!out_valid) begin
                checkOutput("idleData", 64'(out_data), 64'd0);
                checkOutput("idleErr", 64'(out_err), 64'd0);
            end
            if (out_valid && out_ready) begin
                checkOutput("outPending", 64'(occ > 0), 64'd1);
                if (occ > 0) begin
                    e = expQ.pop_front();
                    checkOutput("outErr", 64'(out_err), 64'(e.err));
                    if (!e.err) checkOutput("outData", 64'(out_data), 64'(e.data));
                    if (e.latChk) checkOutput("latency", 64'(cycleCount - e.acceptCycle), 64'd3);
                end
            end
            if (in_valid && in_ready) begin
                e.data        = tbExpData;
                e.err         = tbExpErr;
                e.latChk      = tbLatChk;
                e.acceptCycle = cycleCount;
                expQ.push_back(e);
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic [31:0] expData,
                                 input logic expErr, input logic latChk);
        logic acc;
        int   waits;
        in_valid  = 1'b1;
        in_data   = data;
        tbExpData = expData;
        tbExpErr  = expErr;
        tbLatChk  = latChk;
        acc       = 1'b0;
        waits     = 0;
        while (!acc && waits < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        checkOutput("accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic applyRandomProduct(input logic latChk);
        logic [63:0] a, b, p;
        a = 64'($urandom_range(32'(Q - 64'd1), 0));
        b = 64'($urandom_range(32'(Q - 64'd1), 0));
        p = a * b;
        applyStimulus(p, 32'(p % Q), 1'b0, latChk);
    endtask

    task automatic waitDrain();
        int w;
        w = 0;
        while (expQ.size() != 0 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkOutput("drain", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        tbExpData = 32'd0;
        tbExpErr  = 1'b0;
        tbLatChk  = 1'b0;
        #1;
        checkOutput("rstOutValid", 64'(out_valid), 64'd0);
        checkOutput("rstOutData", 64'(out_data), 64'd0);
        checkOutput("rstOutErr", 64'(out_err), 64'd0);
        checkOutput("rstInReady", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single inputs, the first one on the very first edge after reset release.
        applyStimulus(64'd0, 32'd0, 1'b0, 1'b1);
        idleCycles(4);
        applyStimulus(64'd12345, 32'd12345, 1'b0, 1'b1);
        idleCycles(4);
        applyStimulus(Q, 32'd0, 1'b0, 1'b1);
        idleCycles(4);
        applyStimulus(64'h1_0000_0000, 32'd301989884, 1'b0, 1'b1);
        idleCycles(4);
        applyStimulus((Q - 64'd1) * (Q - 64'd1), 32'd1, 1'b0, 1'b1);
        idleCycles(4);
        applyStimulus(Q - 64'd1, 32'd998244352, 1'b0, 1'b1);
        applyStimulus(64'd2 * Q + 64'd5, 32'd5, 1'b0, 1'b1);
        applyStimulus(QQ - 64'd1, 32'd998244352, 1'b0, 1'b1);
        waitDrain();

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 1000; i++) applyRandomProduct(1'b1);
        waitDrain();

        // Fill the pipe behind a blocked output, then release it.
        rdyFixed = 1'b0;
        idleCycles(1);
        applyStimulus(64'd11, 32'd11, 1'b0, 1'b0);
        applyStimulus(64'd22, 32'd22, 1'b0, 1'b0);
        applyStimulus(64'd33, 32'd33, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stallInReady", 64'(in_ready), 64'd0);
            checkOutput("stallValid", 64'(out_valid), 64'd1);
            checkOutput("stallData", 64'(out_data), 64'd11);
            @(posedge clk);
            #1;
        end
        rdyFixed = 1'b1;
        waitDrain();

        // Out-of-range inputs flag an error without disturbing their successor.
        applyStimulus(QQ, 32'd0, 1'b1, 1'b1);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b1, 1'b1);
        applyStimulus(64'd5, 32'd5, 1'b0, 1'b1);
        waitDrain();

        // Random handshakes on both sides.
        rdyRandom = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            while ($urandom_range(1, 0) == 1) idleCycles(1);
            applyRandomProduct(1'b0);
        end
        rdyRandom = 1'b0;
        rdyFixed  = 1'b1;
        idleCycles(1);
        waitDrain();

        // Asynchronous reset mid-cycle with three results in flight.
        rdyFixed = 1'b0;
        idleCycles(1);
        applyStimulus(64'd101, 32'd101, 1'b0, 1'b0);
        applyStimulus(64'd202, 32'd202, 1'b0, 1'b0);
        applyStimulus(64'd303, 32'd303, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midRstOutValid", 64'(out_valid), 64'd0);
        checkOutput("midRstOutData", 64'(out_data), 64'd0);
        checkOutput("midRstOutErr", 64'(out_err), 64'd0);
        checkOutput("midRstInReady", 64'(in_ready), 64'd1);
        rdyFixed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(6);
        applyStimulus(64'd7, 32'd7, 1'b0, 1'b1);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
